// File: rtl/spi_cmd_rx_pkg.sv
// Shared constants and state encoding for the SPI command receive path.
// The framing bytes are also used by the readout frame builder.
`timescale 1ns/1ps
package spi_cmd_rx_pkg;

    localparam int          CMD_ADDR_W  = 8;
    localparam int          CMD_DATA_W  = 16;
    localparam logic [7:0]  FRAME_START = 8'h7E;
    localparam logic [7:0]  FRAME_END   = 8'h7D;
    localparam int          CNT_W       = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/spi_cmd_rx_sync_edge.sv
// N-stage synchronizer for one asynchronous pin, with a rising-edge flag.
// Reused by the readout SPI path and the trigger input path.
`timescale 1ns/1ps
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Next values of the synchronizer chain and the edge-history flop
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_async};
        prev_d = sync_q[STAGES-1];
    end

    // Synchronizer chain and history flop, cleared to the pin's idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI slave command receiver: oversamples mode-0 SPI pins and deframes
// one 5-byte register-write command per chip-select window.
`timescale 1ns/1ps
module spi_cmd_rx
    import spi_cmd_rx_pkg::*;
#(
    parameter int         ADDR_W      = CMD_ADDR_W,
    parameter int         DATA_W      = CMD_DATA_W,
    parameter logic [7:0] START_BYTE  = FRAME_START,
    parameter logic [7:0] END_BYTE    = FRAME_END,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              sampling_clk,
    input  logic              reset,
    input  logic              clk_async,
    input  logic              cs_async,
    input  logic              si_async,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int               FRAME_BITS = 16 + ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(FRAME_BITS + 1);

    logic sclk_rise_s, sclk_level_unused_s;
    logic cs_s, cs_rise_unused_s;
    logic si_s, si_rise_unused_s;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk(sampling_clk), .rst_n(reset), .d_async(clk_async),
        .level(sclk_level_unused_s), .rise(sclk_rise_s)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(sampling_clk), .rst_n(reset), .d_async(cs_async),
        .level(cs_s), .rise(cs_rise_unused_s)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_si (
        .clk(sampling_clk), .rst_n(reset), .d_async(si_async),
        .level(si_s), .rise(si_rise_unused_s)
    );

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                    wr_en_q, wr_en_d;
    logic                    frame_err_q, frame_err_d;
    logic                    busy_q, busy_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;
    logic                    frame_ok_s;

    assign frame_ok_s = (cnt_q == CNT_FULL)
                      && (shreg_q[FRAME_BITS-1 -: 8] == START_BYTE)
                      && (shreg_q[7:0] == END_BYTE);

    // State register
    always_ff @(posedge sampling_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: chip select alone drives the frame boundaries
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!cs_s) state_d = ST_SHIFT; else state_d = ST_IDLE;
            ST_SHIFT: if (cs_s)  state_d = ST_CHECK; else state_d = ST_SHIFT;
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and output logic; a clock edge coincident with cs rising is dropped
    always_comb begin
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        wr_en_d     = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = (state_d == ST_SHIFT);
        case (state_q)
            ST_IDLE: begin
                if (!cs_s) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ST_SHIFT: begin
                if (!cs_s && sclk_rise_s) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], si_s};
                    cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 6'd1;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ST_CHECK: begin
                if (cnt_q == 6'd0) begin
                    wr_en_d     = 1'b0;
                end else if (frame_ok_s) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = shreg_q[FRAME_BITS-9 -: ADDR_W];
                    wr_data_d   = shreg_q[8 +: DATA_W];
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge sampling_clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            shreg_q     <= '0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Self-checking bench for spi_cmd_rx: a frame-level model predicts each
// write/error pulse and the held register values, checked every cycle.
`timescale 1ns/1ps
module tb_spi_cmd_rx;

    logic        sampling_clk = 1'b0;
    logic        reset        = 1'b1;
    logic        clk_async    = 1'b0;
    logic        cs_async     = 1'b1;
    logic        si_async     = 1'b0;
    logic        wr_en, frame_err, busy;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;

    spi_cmd_rx dut (
        .sampling_clk(sampling_clk), .reset(reset),
        .clk_async(clk_async), .cs_async(cs_async), .si_async(si_async),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 sampling_clk = ~sampling_clk;

    typedef struct {
        time         t;
        bit          is_wr;
        logic [7:0]  addr;
        logic [15:0] data;
    } ev_t;

    ev_t         ev_q[$];
    bit          bits_q[$];
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_data = 16'h0000;
    bit          chk_en = 1'b0;
    bit          exp_wr, exp_err;
    int          n_cmp = 0, n_fail = 0, n_wr = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] field(input int lo, input int n);
        logic [15:0] v = 16'h0000;
        for (int k = 0; k < n; k++) v = {v[14:0], logic'(bits_q[lo + k])};
        return v;
    endfunction

    // A frame closes when cs is raised: a valid one is exactly 40 bits with
    // 7E first and 7D last; an empty window yields nothing. Either pulse
    // is visible 4 sampling cycles after the pin rises (2 sync + 2 pipeline).
    task automatic end_frame();
        ev_t e;
        int  n = bits_q.size();
        if (n != 0) begin
            e.t     = $time + 40;
            e.is_wr = (n == 40) && (field(0, 8) == 16'h007E) && (field(32, 8) == 16'h007D);
            e.addr  = field(8, 8) & 8'hFF;
            e.data  = field(16, 16);
            ev_q.push_back(e);
        end
    endtask

    always @(negedge sampling_clk) begin
        if (reset && chk_en) begin
            exp_wr  = 1'b0;
            exp_err = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].t == $time) begin
                if (ev_q[0].is_wr) begin
                    exp_wr = 1'b1;
                    m_addr = ev_q[0].addr;
                    m_data = ev_q[0].data;
                end else begin
                    exp_err = 1'b1;
                end
                void'(ev_q.pop_front());
            end
            chk("wr_en",     32'(wr_en),     32'(exp_wr));
            chk("frame_err", 32'(frame_err), 32'(exp_err));
            chk("wr_addr",   32'(wr_addr),   32'(m_addr));
            chk("wr_data",   32'(wr_data),   32'(m_data));
            if (wr_en)     n_wr++;
            if (frame_err) n_err++;
        end
    end

    task automatic do_reset();
        reset     = 1'b0;
        cs_async  = 1'b1;
        clk_async = 1'b0;
        si_async  = 1'b0;
        bits_q.delete();
        ev_q.delete();
        m_addr = 8'h00;
        m_data = 16'h0000;
        repeat (3) @(negedge sampling_clk);
        reset = 1'b1;
        repeat (4) @(negedge sampling_clk);
    endtask

    // SPI clock = sampling_clk/8; si changes while the SPI clock is low
    task automatic frame(input logic [63:0] pat, input int nbits, input bit coincide,
                         input int abort_at, input int gap);
        cs_async = 1'b0;
        bits_q.delete();
        repeat (4) @(negedge sampling_clk);
        for (int i = 0; i < nbits; i++) begin
            si_async = pat[nbits - 1 - i];
            repeat (4) @(negedge sampling_clk);
            if (i == abort_at) begin
                do_reset();
                return;
            end
            clk_async = 1'b1;
            if (coincide && i == nbits - 1) begin
                cs_async = 1'b1;
                end_frame();
            end else begin
                bits_q.push_back(si_async);
            end
            if (i == 8) chk("busy_mid", 32'(busy), 32'h1);
            repeat (4) @(negedge sampling_clk);
            clk_async = 1'b0;
        end
        if (!coincide) begin
            repeat (4) @(negedge sampling_clk);
            cs_async = 1'b1;
            end_frame();
        end
        repeat (gap) @(negedge sampling_clk);
        if (gap >= 6) chk("busy_idle", 32'(busy), 32'h0);
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge sampling_clk);
        chk("rst_wr_en",     32'(wr_en),     32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_wr_addr",   32'(wr_addr),   32'h0);
        chk("rst_wr_data",   32'(wr_data),   32'h0);
        reset  = 1'b1;
        chk_en = 1'b1;
        repeat (4) @(negedge sampling_clk);

        frame(64'h7E0512347D, 40, 1'b0, -1, 10);
        chk("lit_addr_1", 32'(wr_addr), 32'h05);
        chk("lit_data_1", 32'(wr_data), 32'h1234);

        frame(64'h7F0512347D, 40, 1'b0, -1, 10);
        chk("lit_addr_bad_start", 32'(wr_addr), 32'h05);
        chk("lit_data_bad_start", 32'(wr_data), 32'h1234);

        frame(64'h3F02891A3E, 39, 1'b0, -1, 10);
        frame(64'h7E0512347D00, 48, 1'b0, -1, 10);
        frame(64'h0, 0, 1'b0, -1, 10);

        frame(64'h7E01AAAA7D, 40, 1'b0, -1, 3);
        frame(64'h7E0255557D, 40, 1'b0, -1, 10);
        chk("lit_addr_b2b", 32'(wr_addr), 32'h02);
        chk("lit_data_b2b", 32'(wr_data), 32'h5555);

        frame(64'h7E10BEEF7D, 40, 1'b0, 20, 10);
        chk("lit_addr_after_rst", 32'(wr_addr), 32'h00);
        frame(64'h7E10BEEF7D, 40, 1'b0, -1, 10);
        chk("lit_addr_beef", 32'(wr_addr), 32'h10);
        chk("lit_data_beef", 32'(wr_data), 32'hBEEF);

        frame(64'h7E0512347D, 40, 1'b1, -1, 10);
        chk("lit_addr_coinc", 32'(wr_addr), 32'h10);
        chk("lit_data_coinc", 32'(wr_data), 32'hBEEF);

        chk("n_wr_pulses",  32'(n_wr),  32'd4);
        chk("n_err_pulses", 32'(n_err), 32'd4);
        chk("events_drained", 32'(ev_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cmd_rx.md
Name: spi_cmd_rx

Overview:
- SPI slave receive path: the command channel from MCU to FPGA on spi_si, the opposite direction of the existing frame readout on spi_so.
- Oversamples the asynchronous SPI pins (mode 0, MSB first) on the PLL clock.
- Deframes one 5-byte write command per chip-select window: 0x7E, addr, data MSB, data LSB, 0x7D.
- A valid frame produces a single-cycle register-write strobe for the configuration register file. Any malformed frame produces an error pulse instead.

Parameters:
- ADDR_W, 8, width of the command address byte
- DATA_W, 16, width of the command data field (two bytes)
- START_BYTE, 8'h7E, required first byte
- END_BYTE, 8'h7D, required last byte
- SYNC_STAGES, 2, flip-flop stages per asynchronous input synchronizer

Ports:
- sampling_clk  in  1  PLL clock; must be at least 4x spi clock frequency
- reset  in  1  asynchronous, active-low reset
- clk_async  in  1  raw SPI clock pin
- cs_async  in  1  raw SPI chip select, active low
- si_async  in  1  raw SPI MOSI pin
- wr_en  out  1  one-cycle write strobe for a valid frame
- wr_addr  out  ADDR_W  command address; held until the next valid frame
- wr_data  out  DATA_W  command data; held until the next valid frame
- frame_err  out  1  one-cycle pulse for a malformed frame
- busy  out  1  high while in the SHIFT state

Behaviour:
- Reset (reset low, asynchronous):
  - wr_en=0, frame_err=0, busy=0, wr_addr=0, wr_data=0.
  - Synchronizers are cleared to idle levels: clk=0, cs=1, si=0.
  - Shift register and bit counter are cleared; state is IDLE.
- Synchronization:
  - Each pin passes through SYNC_STAGES flops.
  - A rising SPI clock edge is detected when the synced clock's previous value was 0 and its current value is 1.
- Bit counter:
  - Width 6 bits; saturates at 41 (41 means overflow).
- Frame length:
  - FRAME_BITS = 8 + ADDR_W + DATA_W + 8 = 40.
  - Shift register is FRAME_BITS wide and shifts left, inserting synced si at the LSB.
- State machine:
  - IDLE:
    - cs_sync=0 -> SHIFT; clear counter and shift register.
  - SHIFT (busy=1):
    - On each rising clock edge, shift in si and increment the counter (saturating).
    - cs_sync=1 -> CHECK.
    - If cs rises in the same cycle as a clock edge, cs takes priority and the edge is discarded.
  - CHECK (single cycle), then always -> IDLE:
    - count == 0: no output (empty select window is ignored).
    - count == 40, top byte == START_BYTE and bottom byte == END_BYTE: register wr_addr and wr_data from bits [31:24] and [23:8]; pulse wr_en on the next cycle.
    - Any other count, or either framing byte wrong: pulse frame_err on the next cycle; wr_addr and wr_data unchanged.
- Latency: wr_en or frame_err asserts exactly 2 sampling_clk cycles after cs_sync first reads high.
- wr_en and frame_err are never high in the same cycle. Each is exactly one cycle wide.
- Back-to-back frames: cs may re-fall immediately. IDLE enters SHIFT on the first cycle it sees cs_sync=0, so no select window is lost.
- Reset mid-frame discards the partial frame with no pulse; the first frame after reset is received normally.
- Clock edges while cs is high are ignored.

Decomposition:
- Shared package holds START_BYTE / END_BYTE frame constants (shared with the readout frame builder) and the state encoding IDLE/SHIFT/CHECK.
- One natural sub-module, sync_edge: an N-stage synchronizer with rising-edge output. It is reusable by the readout SPI path and the trigger input path.
- Instantiate sync_edge three times: clk (edge used), cs (level used), si (level used).

Test Plan:
- Valid frame 7E 05 12 34 7D, SPI clock = sampling_clk/8 -> a single wr_en pulse with wr_addr=0x05, wr_data=0x1234, 2 cycles after cs_sync rises; frame_err stays 0.
- Start byte wrong: 7F 05 12 34 7D -> frame_err pulse; wr_addr/wr_data keep their previous values; no wr_en.
- Length errors:
  - 39 bits -> frame_err.
  - 48 bits (extra byte 00 after 7D) -> frame_err.
  - cs low with zero clocks -> no pulse at all.
- Two valid frames back to back (cs high for 3 sampling_clk cycles between them), writing 0x01/0xAAAA then 0x02/0x5555 -> two wr_en pulses with the correct values, in order.
- Reset asserted after 20 bits of a frame, then a full valid frame 7E 10 BE EF 7D -> no pulse for the aborted frame; then wr_en with addr 0x10, data 0xBEEF.
- Clock edge coincident with cs rising on the final bit of 7E 05 12 34 7D -> the edge is discarded, count=39, frame_err.
